// File: rtl/ibex_fetch_req_sched_pkg.sv
// Shared types for the instruction fetch request scheduler.
// Holds the scheduler FSM encoding and the fetch address increment.
package ibex_fetch_req_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } fetch_sched_state_e;

  localparam logic [31:0] FETCH_ADDR_INCR = 32'd4;

endpackage

// File: rtl/ibex_fetch_req_sched_tracker.sv
// Outstanding/discard bookkeeping for fetch requests.
// Computes FIFO room so every in-flight response has a slot.
module ibex_fetch_req_sched_tracker #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic                gnt_i,
  input  logic                disc_gnt_i,
  input  logic                rvalid_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                can_issue_o,
  output logic                can_issue_next_o,
  output logic                busy_o,
  output logic                keep_o
);

  logic [NUM_REQS-1:0] out_q, disc_q;
  logic [NUM_REQS-1:0] out_d, disc_d;
  logic [NUM_REQS-1:0] out_s, disc_s;
  logic [NUM_REQS-1:0] slot_s, slot_q;
  logic [NUM_REQS-1:0] out_g;
  logic [NUM_REQS-1:0] rev_q, rev_g;
  logic                rv;

  assign rv     = rvalid_i & out_q[0];
  assign out_s  = rv ? (out_q >> 1) : out_q;
  assign disc_s = rv ? (disc_q >> 1) : disc_q;
  assign slot_s = ~out_s & ((out_s << 1) | NUM_REQS'(1));
  assign slot_q = ~out_q & ((out_q << 1) | NUM_REQS'(1));

  assign out_d  = gnt_i ? (out_s | slot_s) : out_s;
  assign disc_d = disc_s
                | (branch_i ? out_s : '0)
                | ((gnt_i & disc_gnt_i) ? slot_s : '0);

  // Lookahead ignores a same-cycle retire, so it never overcommits
  assign out_g = gnt_i ? (out_q | slot_q) : out_q;

  always_comb begin
    rev_q = '0;
    rev_g = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rev_q[i] = out_q[NUM_REQS-1-i];
      rev_g[i] = out_g[NUM_REQS-1-i];
    end
  end

  assign can_issue_o = req_i
                     & ~&(fifo_busy_i | rev_q)
                     & ~out_q[NUM_REQS-1];
  assign can_issue_next_o = req_i
                          & ~&(fifo_busy_i | rev_g)
                          & ~out_g[NUM_REQS-1];

  assign busy_o = |out_q;
  assign keep_o = out_q[0] & ~disc_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

endmodule

// File: rtl/ibex_fetch_req_sched.sv
// Instruction fetch request scheduler: OBI request FSM and
// fetch address tracking in front of the fetch FIFO.
module ibex_fetch_req_sched
  import ibex_fetch_req_sched_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  output logic                busy_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic                instr_err_i
);

  fetch_sched_state_e state_q;
  logic [31:0]        fetch_addr_q;
  logic [31:0]        pend_addr_q;
  logic               pend_br_q;
  logic [31:0]        br_word;
  logic               gnt;
  logic               disc_gnt;
  logic               can_issue;
  logic               can_issue_next;
  logic               out_busy;
  logic               keep;
  logic               unused_err;

  assign unused_err = instr_err_i;

  assign br_word  = {branch_addr_i[31:2], 2'b00};
  assign gnt      = instr_gnt_i & instr_req_o;
  assign disc_gnt = branch_i | ((state_q == HOLD) & pend_br_q);

  ibex_fetch_req_sched_tracker #(
    .NUM_REQS(NUM_REQS)
  ) u_tracker (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .branch_i        (branch_i),
    .gnt_i           (gnt),
    .disc_gnt_i      (disc_gnt),
    .rvalid_i        (instr_rvalid_i),
    .fifo_busy_i     (fifo_busy_i),
    .can_issue_o     (can_issue),
    .can_issue_next_o(can_issue_next),
    .busy_o          (out_busy),
    .keep_o          (keep)
  );

  assign instr_req_o  = (state_q != IDLE);
  assign instr_addr_o = fetch_addr_q;
  assign busy_o       = out_busy | instr_req_o;
  assign fifo_valid_o = instr_rvalid_i & keep;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = branch_addr_i;

  // An ungranted request must hold its address, so branches park in pend
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pend_addr_q  <= '0;
      pend_br_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (branch_i) fetch_addr_q <= br_word;
          if (can_issue) state_q <= ISSUE;
        end
        ISSUE: begin
          if (instr_gnt_i) begin
            fetch_addr_q <= branch_i ? br_word
                                     : fetch_addr_q + FETCH_ADDR_INCR;
            state_q <= can_issue_next ? ISSUE : IDLE;
          end else begin
            state_q <= HOLD;
            if (branch_i) begin
              pend_addr_q <= br_word;
              pend_br_q   <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (instr_gnt_i) begin
            if (branch_i)
              fetch_addr_q <= br_word;
            else if (pend_br_q)
              fetch_addr_q <= pend_addr_q;
            else
              fetch_addr_q <= fetch_addr_q + FETCH_ADDR_INCR;
            pend_br_q <= 1'b0;
            state_q   <= can_issue_next ? ISSUE : IDLE;
          end else if (branch_i) begin
            pend_addr_q <= br_word;
            pend_br_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  gnt_without_req: assert property (
    @(posedge clk_i) disable iff (rst_i)
    instr_gnt_i |-> instr_req_o
  );

endmodule

// File: tb/tb_ibex_fetch_req_sched.sv
// Directed cycle-table bench for ibex_fetch_req_sched.
// Each row drives one cycle and checks that cycle's outputs.
module tb_ibex_fetch_req_sched;

  typedef struct {
    logic        rst;
    logic        req;
    logic        br;
    logic [31:0] ba;
    logic [1:0]  fb;
    logic        gnt;
    logic        rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        busy_o;
  logic [1:0]  fifo_busy_i = '0;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic        instr_err_i = 1'b0;

  int total = 0;
  int passed = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ibex_fetch_req_sched #(.NUM_REQS(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .busy_o        (busy_o),
    .fifo_busy_i   (fifo_busy_i),
    .fifo_clear_o  (fifo_clear_o),
    .fifo_valid_o  (fifo_valid_o),
    .fifo_addr_o   (fifo_addr_o),
    .instr_req_o   (instr_req_o),
    .instr_gnt_i   (instr_gnt_i),
    .instr_addr_o  (instr_addr_o),
    .instr_rvalid_i(instr_rvalid_i),
    .instr_err_i   (instr_err_i)
  );

  task automatic add(input logic rst, req, br, input logic [31:0] ba,
                     input logic [1:0] fb, input logic gnt, rv,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic efv, ebusy);
    vec_t v;
    v.rst = rst; v.req = req; v.br = br; v.ba = ba; v.fb = fb;
    v.gnt = gnt; v.rv = rv; v.e_req = ereq; v.e_addr = eaddr;
    v.e_fv = efv; v.e_busy = ebusy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row,
                     input logic [31:0] act, exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s row %0d: got %h expected %h",
                  name, row, act, exp);
  endtask

  initial begin
    int grants;
    int pushes;
    //   rst req br ba            fb    gnt rv  req addr          fv busy
    add(1, 0, 0, 32'h0,        2'b00, 0, 0,  0, 32'h0,        0, 0);
    add(1, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h0,        0, 0);
    add(0, 1, 1, 32'h100,      2'b00, 0, 0,  0, 32'h0,        0, 0);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h100,      0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 1, 1,  1, 32'h104,      1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 1,  0, 32'h108,      1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h108,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 1, 1,  1, 32'h10C,      1, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h110,      1, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 0,  0, 32'h110,      0, 0);
    add(0, 1, 0, 32'h0,        2'b01, 0, 0,  0, 32'h110,      0, 0);
    add(0, 1, 0, 32'h0,        2'b01, 1, 0,  1, 32'h110,      0, 1);
    add(0, 1, 0, 32'h0,        2'b01, 0, 0,  0, 32'h114,      0, 1);
    add(0, 1, 0, 32'h0,        2'b01, 0, 0,  0, 32'h114,      0, 1);
    add(0, 1, 0, 32'h0,        2'b01, 0, 1,  0, 32'h114,      1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  0, 32'h114,      0, 0);
    add(0, 0, 0, 32'h0,        2'b00, 1, 0,  1, 32'h114,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h118,      1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  0, 32'h118,      0, 0);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  1, 32'h118,      0, 1);
    add(0, 1, 1, 32'h2002,     2'b00, 0, 0,  1, 32'h118,      0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  1, 32'h118,      0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h118,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  1, 32'h2000,     0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 1, 0,  1, 32'h2000,     0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h2004,     1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  0, 32'h2004,     0, 0);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h2004,     0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h2008,     0, 1);
    add(0, 1, 1, 32'h400,      2'b00, 0, 0,  0, 32'h200C,     0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 1,  0, 32'h400,      0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 1,  0, 32'h400,      0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h400,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  1, 32'h404,      1, 1);
    add(0, 0, 0, 32'h0,        2'b00, 1, 0,  1, 32'h404,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h408,      1, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 0,  0, 32'h408,      0, 0);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  0, 32'h408,      0, 0);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h408,      0, 1);
    add(0, 1, 1, 32'h803,      2'b00, 1, 1,  1, 32'h40C,      1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 1,  0, 32'h800,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 1, 0,  1, 32'h800,      0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h804,      1, 1);
    add(0, 1, 1, 32'hFFFFFFFC, 2'b00, 0, 0,  0, 32'h804,      0, 0);
    add(0, 0, 0, 32'h0,        2'b00, 1, 0,  1, 32'hFFFFFFFC, 0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 1,  0, 32'h0,        1, 1);
    add(0, 0, 0, 32'h0,        2'b00, 1, 0,  1, 32'h0,        0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h4,        1, 1);
    add(0, 1, 0, 32'h0,        2'b00, 0, 0,  0, 32'h4,        0, 0);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h4,        0, 1);
    add(0, 1, 0, 32'h0,        2'b00, 1, 0,  1, 32'h8,        0, 1);
    add(1, 1, 0, 32'h0,        2'b00, 0, 0,  0, 32'hC,        0, 1);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,        2'b00, 0, 1,  0, 32'h0,        0, 0);

    @(posedge clk);
    foreach (tbl[r]) begin
      @(posedge clk);
      #1;
      rst_i          = tbl[r].rst;
      req_i          = tbl[r].req;
      branch_i       = tbl[r].br;
      branch_addr_i  = tbl[r].ba;
      fifo_busy_i    = tbl[r].fb;
      instr_gnt_i    = tbl[r].gnt;
      instr_rvalid_i = tbl[r].rv;
      @(negedge clk);
      chk("instr_req", r, 32'(instr_req_o), 32'(tbl[r].e_req));
      chk("instr_addr", r, instr_addr_o, tbl[r].e_addr);
      chk("fifo_valid", r, 32'(fifo_valid_o), 32'(tbl[r].e_fv));
      chk("busy", r, 32'(busy_o), 32'(tbl[r].e_busy));
      chk("fifo_clear", r, 32'(fifo_clear_o), 32'(tbl[r].br));
      chk("fifo_addr", r, fifo_addr_o, tbl[r].ba);
    end

    // Saturate: grant whenever asked, no responses; only two may issue
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      rst_i = 1'b0; req_i = 1'b1; branch_i = 1'b0;
      fifo_busy_i = '0; instr_rvalid_i = 1'b0;
      instr_gnt_i = instr_req_o;
      @(negedge clk);
      if (instr_req_o && instr_gnt_i) grants++;
    end
    chk("sat_grants", 100, 32'(grants), 32'd2);
    chk("sat_req_low", 101, 32'(instr_req_o), 32'd0);

    // Drain both responses within a bounded window
    pushes = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      req_i = 1'b0; instr_gnt_i = 1'b0;
      instr_rvalid_i = busy_o;
      @(negedge clk);
      if (fifo_valid_o) pushes++;
    end
    chk("drain_pushes", 102, 32'(pushes), 32'd2);
    chk("drain_idle", 103, 32'(busy_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
